// File: rtl/piso_pkg.sv
// Shared types and constants for the piso_reader8 serializer.
// Imported by the top and its bit counter.
package piso_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Beat counter for the serializer: counts transferred bits and
// flags the final bit position of a word.
module piso_bit_cnt
  import piso_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic last_o
);

  localparam int CNT_W = cnt_w(WIDTH);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/piso_reader8.sv
// Parallel-in serial-out reader: accepts a word over valid/ready
// and streams it one bit per accepted beat, pulsing done at the end.
module piso_reader8
  import piso_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             s_out,
  output logic             s_valid,
  input  logic             s_ready,
  output logic             done
);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic             done_q;
  logic             done_d;
  logic             load_acc;
  logic             beat;
  logic             last;

  assign load_acc = (state_q == ST_IDLE) && load_valid;
  assign beat     = (state_q == ST_SHIFT) && s_ready;

  piso_bit_cnt #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk    (clk),
    .rst    (reset),
    .en_i   (beat),
    .clr_i  (load_acc || (beat && last)),
    .last_o (last)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          shreg_d = d;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (s_ready) begin
          // Shift toward the output end, zero-filling behind.
          if (LSB_FIRST != 0) begin
            shreg_d = shreg_q >> 1;
          end else begin
            shreg_d = shreg_q << 1;
          end
          if (last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      done_q  <= done_d;
    end
  end

  logic out_bit;

  always_comb begin
    if (LSB_FIRST != 0) begin
      out_bit = shreg_q[0];
    end else begin
      out_bit = shreg_q[WIDTH-1];
    end
  end

  assign load_ready = (state_q == ST_IDLE);
  assign s_valid    = (state_q == ST_SHIFT);
  assign s_out      = s_valid && out_bit;
  assign done       = done_q;

endmodule

// File: tb/tb_piso_reader8.sv
// Directed bench for piso_reader8: LSB-first and MSB-first
// instances share one stimulus stream.
module tb_piso_reader8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] d;
  logic       load_valid;
  logic       s_ready;

  logic l_ready, l_out, l_valid, l_done;
  logic m_ready, m_out, m_valid, m_done;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  piso_reader8 #(.WIDTH(8), .LSB_FIRST(1)) u_lsb (
    .clk        (clk),
    .reset      (reset),
    .d          (d),
    .load_valid (load_valid),
    .load_ready (l_ready),
    .s_out      (l_out),
    .s_valid    (l_valid),
    .s_ready    (s_ready),
    .done       (l_done)
  );

  piso_reader8 #(.WIDTH(8), .LSB_FIRST(0)) u_msb (
    .clk        (clk),
    .reset      (reset),
    .d          (d),
    .load_valid (load_valid),
    .load_ready (m_ready),
    .s_out      (m_out),
    .s_valid    (m_valid),
    .s_ready    (s_ready),
    .done       (m_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " l_valid"}, l_valid, 1'b0);
    chk({tag, " l_ready"}, l_ready, 1'b1);
    chk({tag, " l_out"}, l_out, 1'b0);
  endtask

  logic [7:0] a5 = 8'hA5;
  logic [7:0] h3c = 8'h3C;

  initial begin
    // Reset with random inputs
    reset = 1'b1;
    d = 8'($urandom);
    load_valid = 1'($urandom);
    s_ready = 1'($urandom);
    tick();
    d = 8'($urandom);
    load_valid = 1'($urandom);
    s_ready = 1'($urandom);
    tick();
    chk_idle("rst");
    chk("rst l_done", l_done, 1'b0);
    chk("rst m_valid", m_valid, 1'b0);
    chk("rst m_ready", m_ready, 1'b1);
    chk("rst m_out", m_out, 1'b0);
    chk("rst m_done", m_done, 1'b0);
    reset = 1'b0;
    load_valid = 1'b0;
    s_ready = 1'b1;
    tick();

    // LSB and MSB order, word 8'h01
    d = 8'h01;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    d = 8'h00;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("ord l_out%0d", k), l_out, k == 0);
      chk($sformatf("ord m_out%0d", k), m_out, k == 7);
      chk($sformatf("ord l_valid%0d", k), l_valid, 1'b1);
      chk($sformatf("ord m_valid%0d", k), m_valid, 1'b1);
      chk($sformatf("ord l_ready%0d", k), l_ready, 1'b0);
      chk($sformatf("ord l_done%0d", k), l_done, 1'b0);
      chk($sformatf("ord m_done%0d", k), m_done, 1'b0);
      tick();
    end
    chk("ord l_done", l_done, 1'b1);
    chk("ord m_done", m_done, 1'b1);
    chk_idle("ord end");
    tick();
    chk("ord l_done2", l_done, 1'b0);
    chk("ord m_done2", m_done, 1'b0);
    chk("ord l_ready2", l_ready, 1'b1);

    // Backpressure on 8'hA5
    d = a5;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    chk("bp bit0", l_out, 1'b1);
    tick();
    chk("bp bit1", l_out, 1'b0);
    tick();
    s_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp hold%0d", k), l_out, 1'b1);
      chk($sformatf("bp valid%0d", k), l_valid, 1'b1);
      chk($sformatf("bp done%0d", k), l_done, 1'b0);
      tick();
    end
    s_ready = 1'b1;
    for (int k = 2; k < 8; k++) begin
      chk($sformatf("bp bit%0d", k), l_out, a5[k]);
      chk($sformatf("bp v%0d", k), l_valid, 1'b1);
      tick();
    end
    chk("bp done", l_done, 1'b1);
    chk("bp ready", l_ready, 1'b1);
    tick();

    // Load attempt during SHIFT
    d = 8'hFF;
    load_valid = 1'b1;
    tick();
    d = h3c;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("ld ff%0d", k), l_out, 1'b1);
      chk($sformatf("ld ready%0d", k), l_ready, 1'b0);
      tick();
    end
    chk("ld done", l_done, 1'b1);
    chk("ld ready", l_ready, 1'b1);
    tick();
    load_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("ld 3c%0d", k), l_out, h3c[k]);
      chk($sformatf("ld v%0d", k), l_valid, 1'b1);
      chk($sformatf("ld nd%0d", k), l_done, 1'b0);
      tick();
    end
    chk("ld done2", l_done, 1'b1);
    tick();

    // Reset mid-word
    d = 8'hF0;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("mid f0%0d", k), l_out, 1'b0);
      tick();
    end
    chk("mid bit4", l_out, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_idle("mid rst");
    chk("mid done", l_done, 1'b0);
    chk("mid m_valid", m_valid, 1'b0);
    tick();
    chk("mid done2", l_done, 1'b0);
    chk("mid m_done2", m_done, 1'b0);
    d = 8'hFF;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("mid l_ff%0d", k), l_out, 1'b1);
      chk($sformatf("mid m_ff%0d", k), m_out, 1'b1);
      tick();
    end
    chk("mid l_done3", l_done, 1'b1);
    chk("mid m_done3", m_done, 1'b1);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
